// File: rtl/chip8_pkg.sv
// Shared CHIP-8 constants: bus widths, memory-arbiter state encoding and requester IDs.
package chip8_pkg;

   localparam int CHIP8_ADDR_W = 12;
   localparam int CHIP8_DATA_W = 8;

   localparam logic [1:0] MEMARB_IDLE   = 2'd0;
   localparam logic [1:0] MEMARB_CPU_RD = 2'd1;
   localparam logic [1:0] MEMARB_GPU_RD = 2'd2;
   localparam logic [1:0] MEMARB_CPU_WR = 2'd3;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_GPU = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = MEMARB_IDLE,
      ST_CPU_RD = MEMARB_CPU_RD,
      ST_GPU_RD = MEMARB_GPU_RD,
      ST_CPU_WR = MEMARB_CPU_WR
   } memarb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// CPU/GPU arbiter for the single-ported CHIP-8 memory; one transaction in flight, registered outputs.
// MEM_ARB_CPU_PRIORITY_EN selects fixed CPU priority instead of round-robin.
module mem_arbiter
   import chip8_pkg::*;
#(
   parameter int ADDR_W = CHIP8_ADDR_W,
   parameter int DATA_W = CHIP8_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_read,
   input  logic [ADDR_W-1:0] cpu_read_addr,
   output logic [DATA_W-1:0] cpu_read_data,
   output logic              cpu_read_ack,
   input  logic              cpu_write,
   input  logic [ADDR_W-1:0] cpu_write_addr,
   input  logic [DATA_W-1:0] cpu_write_data,
   output logic              cpu_write_ack,
   input  logic              gpu_read,
   input  logic [ADDR_W-1:0] gpu_read_addr,
   output logic [DATA_W-1:0] gpu_read_data,
   output logic              gpu_read_ack,
   output logic              mem_read,
   output logic [ADDR_W-1:0] mem_read_addr,
   input  logic [DATA_W-1:0] mem_read_data,
   input  logic              mem_read_ack,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_write_addr,
   output logic [DATA_W-1:0] mem_write_data
);

   memarb_state_e     state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              mem_read_q, mem_read_d;
   logic [ADDR_W-1:0] mem_read_addr_q, mem_read_addr_d;
   logic              mem_write_q, mem_write_d;
   logic [ADDR_W-1:0] mem_write_addr_q, mem_write_addr_d;
   logic [DATA_W-1:0] mem_write_data_q, mem_write_data_d;
   logic [DATA_W-1:0] cpu_read_data_q, cpu_read_data_d;
   logic              cpu_read_ack_q, cpu_read_ack_d;
   logic              cpu_write_ack_q, cpu_write_ack_d;
   logic [DATA_W-1:0] gpu_read_data_q, gpu_read_data_d;
   logic              gpu_read_ack_q, gpu_read_ack_d;

   logic cpu_req;
   logic gpu_req;
   logic grant_valid;
   logic grant_id;

   // A requester whose ack is visible this cycle may still be holding its request; ignore it.
   always_comb begin
      cpu_req     = (cpu_read | cpu_write) & ~(cpu_read_ack_q | cpu_write_ack_q);
      gpu_req     = gpu_read & ~gpu_read_ack_q;
      grant_valid = cpu_req | gpu_req;
      grant_id    = REQ_CPU;
      if (cpu_req && gpu_req) begin
`ifdef MEM_ARB_CPU_PRIORITY_EN
         grant_id = REQ_CPU;
`else
         grant_id = (last_grant_q == REQ_GPU) ? REQ_CPU : REQ_GPU;
`endif
      end else if (gpu_req) begin
         grant_id = REQ_GPU;
      end
   end

   always_comb begin
      state_d          = state_q;
      last_grant_d     = last_grant_q;
      mem_read_d       = mem_read_q;
      mem_read_addr_d  = mem_read_addr_q;
      mem_write_d      = 1'b0;
      mem_write_addr_d = mem_write_addr_q;
      mem_write_data_d = mem_write_data_q;
      cpu_read_data_d  = cpu_read_data_q;
      cpu_read_ack_d   = 1'b0;
      cpu_write_ack_d  = 1'b0;
      gpu_read_data_d  = gpu_read_data_q;
      gpu_read_ack_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (grant_valid) begin
               last_grant_d = grant_id;
               if (grant_id == REQ_GPU) begin
                  state_d         = ST_GPU_RD;
                  mem_read_d      = 1'b1;
                  mem_read_addr_d = gpu_read_addr;
               end else if (cpu_read) begin
                  state_d         = ST_CPU_RD;
                  mem_read_d      = 1'b1;
                  mem_read_addr_d = cpu_read_addr;
               end else begin
                  // Writes complete in one strobe, so the ack goes out alongside it.
                  state_d          = ST_CPU_WR;
                  mem_write_d      = 1'b1;
                  mem_write_addr_d = cpu_write_addr;
                  mem_write_data_d = cpu_write_data;
                  cpu_write_ack_d  = 1'b1;
               end
            end
         end
         ST_CPU_RD: begin
            if (mem_read_ack) begin
               state_d         = ST_IDLE;
               mem_read_d      = 1'b0;
               cpu_read_data_d = mem_read_data;
               cpu_read_ack_d  = 1'b1;
            end
         end
         ST_GPU_RD: begin
            if (mem_read_ack) begin
               state_d         = ST_IDLE;
               mem_read_d      = 1'b0;
               gpu_read_data_d = mem_read_data;
               gpu_read_ack_d  = 1'b1;
            end
         end
         ST_CPU_WR: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= ST_IDLE;
         last_grant_q     <= REQ_GPU;
         mem_read_q       <= 1'b0;
         mem_read_addr_q  <= '0;
         mem_write_q      <= 1'b0;
         mem_write_addr_q <= '0;
         mem_write_data_q <= '0;
         cpu_read_data_q  <= '0;
         cpu_read_ack_q   <= 1'b0;
         cpu_write_ack_q  <= 1'b0;
         gpu_read_data_q  <= '0;
         gpu_read_ack_q   <= 1'b0;
      end else begin
         state_q          <= state_d;
         last_grant_q     <= last_grant_d;
         mem_read_q       <= mem_read_d;
         mem_read_addr_q  <= mem_read_addr_d;
         mem_write_q      <= mem_write_d;
         mem_write_addr_q <= mem_write_addr_d;
         mem_write_data_q <= mem_write_data_d;
         cpu_read_data_q  <= cpu_read_data_d;
         cpu_read_ack_q   <= cpu_read_ack_d;
         cpu_write_ack_q  <= cpu_write_ack_d;
         gpu_read_data_q  <= gpu_read_data_d;
         gpu_read_ack_q   <= gpu_read_ack_d;
      end
   end

   assign cpu_read_data  = cpu_read_data_q;
   assign cpu_read_ack   = cpu_read_ack_q;
   assign cpu_write_ack  = cpu_write_ack_q;
   assign gpu_read_data  = gpu_read_data_q;
   assign gpu_read_ack   = gpu_read_ack_q;
   assign mem_read       = mem_read_q;
   assign mem_read_addr  = mem_read_addr_q;
   assign mem_write      = mem_write_q;
   assign mem_write_addr = mem_write_addr_q;
   assign mem_write_data = mem_write_data_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-ported 4 KiB memory (one read channel with ack, one write channel) between the CPU and the GPU.
- The GPU reads sprite bytes for DXYN; the CPU performs instruction and data reads and writes.
- Sits between cpu/gpu and memory in chip8: a round-robin grant FSM with registered outputs and a one-transaction-at-a-time discipline.

Parameters:
- ADDR_W, 12, memory address width.
- DATA_W, 8, memory data width.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- cpu_read  input  1  CPU read request; held until cpu_read_ack
- cpu_read_addr  input  ADDR_W  CPU read address; stable while cpu_read is high
- cpu_read_data  output  DATA_W  read data; valid in the cpu_read_ack cycle
- cpu_read_ack  output  1  one-cycle completion pulse
- cpu_write  input  1  CPU write request; held until cpu_write_ack
- cpu_write_addr  input  ADDR_W  write address
- cpu_write_data  input  DATA_W  write data
- cpu_write_ack  output  1  one-cycle completion pulse
- gpu_read  input  1  GPU read request; held until gpu_read_ack
- gpu_read_addr  input  ADDR_W  GPU read address
- gpu_read_data  output  DATA_W  read data; valid in the gpu_read_ack cycle
- gpu_read_ack  output  1  one-cycle completion pulse
- mem_read  output  1  memory read strobe; held until mem_read_ack
- mem_read_addr  output  ADDR_W  memory read address
- mem_read_data  input  DATA_W  memory read data; valid with mem_read_ack
- mem_read_ack  input  1  memory read completion
- mem_write  output  1  one-cycle memory write strobe
- mem_write_addr  output  ADDR_W  memory write address
- mem_write_data  output  DATA_W  memory write data

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- All outputs are registered.
- Reset values: every output is 0, state IDLE, last_grant=GPU (so the CPU wins first).
- FSM states: IDLE, CPU_RD, GPU_RD, CPU_WR.
- Request masking: in IDLE, a requester whose ack output is high this cycle is masked. This lets it drop its request without the arbiter reissuing it.
- CPU request selection: if cpu_read and cpu_write are both high, the read wins.
- Arbitration in IDLE: if both CPU and GPU request, the one not equal to last_grant wins. On grant, last_grant is updated.
- IDLE->CPU_RD/GPU_RD (decision in cycle N):
  - mem_read=1 and mem_read_addr=the winner's address from N+1.
  - mem_read stays high until mem_read_ack is sampled.
- Read completion (mem_read_ack sampled in cycle M):
  - At M+1: mem_read=0; the requester's read_data is latched from mem_read_data; its ack pulses for exactly 1 cycle; state returns to IDLE.
  - Read latency is 2 cycles plus memory latency.
- IDLE->CPU_WR (cycle N):
  - At N+1: mem_write=1, addr/data driven, and cpu_write_ack=1, for exactly 1 cycle.
  - State returns to IDLE at N+2.
- Read data outputs hold their last value between acks.
- mem_read_ack while in IDLE or CPU_WR (stale, e.g. after reset mid-read): ignored, no ack is generated.
- Requester deasserting its request mid-transaction: the transaction still completes and the ack is still pulsed.
- Reset mid-transaction: immediate return to the reset values. The in-flight memory read is abandoned and its ack is ignored per the stale-ack rule.
- Throughput: at most one memory transaction is outstanding. Back-to-back requests from both masters alternate.

Optional Feature:
- Macro: MEM_ARB_CPU_PRIORITY_EN.
- Defined: fixed priority; the CPU always wins a simultaneous request and last_grant is unused.
- Undefined: round-robin as above.
- Both builds must meet the same handshake timing.

Decomposition:
- Shared package chip8_pkg holds:
  - state encoding constants MEMARB_IDLE/CPU_RD/GPU_RD/CPU_WR (2 bits);
  - requester ID constants REQ_CPU=0 and REQ_GPU=1;
  - CHIP8_ADDR_W=12 and CHIP8_DATA_W=8.
- No sub-module. The selection logic is small enough to stay inline in mem_arbiter.

Test Plan:
- Single read: cpu_read addr 0x200, memory acks 2 cycles later with 0xA2 -> cpu_read_ack pulses once, cpu_read_data=0xA2, mem_read low afterwards, no reissue while the CPU drops its request.
- Single write: cpu_write addr 0x300 data 0x5C -> mem_write high for exactly 1 cycle with 0x300/0x5C, cpu_write_ack in the same cycle, return to IDLE next cycle.
- Contention: CPU and GPU both request continuously from reset -> grants CPU, GPU, CPU, GPU… With MEM_ARB_CPU_PRIORITY_EN defined, the GPU starves while the CPU requests.
- CPU read+write simultaneous, with the GPU also requesting -> CPU read is served first, then GPU, then CPU write; mem_write never overlaps mem_read.
- Reset mid-read: assert rst while in GPU_RD, then deliver mem_read_ack after release -> no gpu_read_ack, all outputs 0, and the next request proceeds normally.
- Late drop: the GPU deasserts gpu_read one cycle after grant -> the read completes and gpu_read_ack still pulses once.
